// File: rtl/top_melody_sequencer.sv
// Plays a fixed 16-entry melody table as timed tone/gap pairs for a frequency generator.
// Optional build macro MELODY_SEQUENCER_LOOP_EN: repeat the song forever instead of finishing.
module top_melody_sequencer #(
   parameter int unsigned BEAT_CYCLES = 12_500_000,
   parameter int unsigned GAP_CYCLES  = 1_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_stop,
   output logic [15:0] o_freq,
   output logic [3:0]  o_en,
   output logic        o_busy,
   output logic [3:0]  o_note_idx,
   output logic        o_done
);

   localparam int unsigned FREQ_W  = 16;
   localparam int unsigned BEATS_W = 4;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned EN_W    = 4;

   localparam logic [EN_W-1:0]  EN_ON    = 4'hF;
   localparam logic [EN_W-1:0]  EN_OFF   = 4'h0;
   localparam logic [IDX_W-1:0] IDX_LAST = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TONE,
      S_GAP,
      S_DONE
   } state_t;

`ifdef MELODY_SEQUENCER_LOOP_EN
   localparam state_t END_STATE = S_LOAD;
   localparam logic   END_DONE  = 1'b0;
`else
   localparam state_t END_STATE = S_DONE;
   localparam logic   END_DONE  = 1'b1;
`endif

   // Song table entry: {freq_hz, beats}; beats == 0 marks the end of the song.
   function automatic logic [FREQ_W+BEATS_W-1:0] song_entry(input logic [IDX_W-1:0] idx);
      case (idx)
         4'd0:    song_entry = {16'd262, 4'd2};
         4'd1:    song_entry = {16'd294, 4'd2};
         4'd2:    song_entry = {16'd330, 4'd2};
         4'd3:    song_entry = {16'd349, 4'd2};
         4'd4:    song_entry = {16'd392, 4'd4};
         4'd5:    song_entry = {16'd0,   4'd2};
         4'd6:    song_entry = {16'd392, 4'd2};
         4'd7:    song_entry = {16'd349, 4'd2};
         4'd8:    song_entry = {16'd330, 4'd2};
         4'd9:    song_entry = {16'd294, 4'd2};
         4'd10:   song_entry = {16'd262, 4'd4};
         default: song_entry = {16'd0,   4'd0};
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_d;
   logic [FREQ_W-1:0]   freq_d;
   logic [EN_W-1:0]     en_d;
   logic                busy_d;
   logic                done_d;
   logic [FREQ_W+BEATS_W-1:0] entry;
   logic [FREQ_W-1:0]   entry_freq;
   logic [BEATS_W-1:0]  entry_beats;

   assign entry       = song_entry(o_note_idx);
   assign entry_freq  = entry[FREQ_W+BEATS_W-1:BEATS_W];
   assign entry_beats = entry[BEATS_W-1:0];

   // Next-state and next-output logic; stop beats start, start restarts from note 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = o_note_idx;
      freq_d  = o_freq;
      en_d    = o_en;
      done_d  = 1'b0;

      if (i_stop) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         freq_d  = '0;
         en_d    = EN_OFF;
      end else if (i_start) begin
         state_d = S_LOAD;
         cnt_d   = '0;
         idx_d   = '0;
         freq_d  = '0;
         en_d    = EN_OFF;
      end else begin
         case (state_q)
            S_IDLE: begin
               freq_d = '0;
               en_d   = EN_OFF;
            end
            S_LOAD: begin
               if (entry_beats == '0) begin
                  state_d = END_STATE;
                  done_d  = END_DONE;
                  idx_d   = '0;
                  freq_d  = '0;
                  en_d    = EN_OFF;
               end else begin
                  state_d = S_TONE;
                  cnt_d   = CNT_W'(entry_beats) * CNT_W'(BEAT_CYCLES);
                  freq_d  = entry_freq;
                  en_d    = (entry_freq != '0) ? EN_ON : EN_OFF;
               end
            end
            S_TONE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = S_GAP;
                  cnt_d   = CNT_W'(GAP_CYCLES);
                  freq_d  = '0;
                  en_d    = EN_OFF;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_d = '0;
                  if (o_note_idx == IDX_LAST) begin
                     state_d = END_STATE;
                     done_d  = END_DONE;
                     idx_d   = '0;
                  end else begin
                     state_d = S_LOAD;
                     idx_d   = o_note_idx + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               freq_d  = '0;
               en_d    = EN_OFF;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
               freq_d  = '0;
               en_d    = EN_OFF;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, counter and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         o_note_idx <= '0;
         o_freq     <= '0;
         o_en       <= EN_OFF;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         o_note_idx <= idx_d;
         o_freq     <= freq_d;
         o_en       <= en_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
      end
   end

endmodule

// File: tb/tb_top_melody_sequencer.sv
// Scoreboard bench: expected output runs (value tuple + cycle length) are queued by the
// stimulus; the monitor closes a run whenever the output tuple changes and compares it.
module tb_top_melody_sequencer;

   localparam int unsigned BEAT = 10;
   localparam int unsigned GAP  = 2;
   localparam int          WAIT_LIMIT = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [15:0] o_freq;
   logic [3:0]  o_en;
   logic        o_busy;
   logic [3:0]  o_note_idx;
   logic        o_done;

   top_melody_sequencer #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES (GAP)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_start   (start),
      .i_stop    (stop),
      .o_freq    (o_freq),
      .o_en      (o_en),
      .o_busy    (o_busy),
      .o_note_idx(o_note_idx),
      .o_done    (o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [25:0] t;
      int          len;   // 0 = length not checked
   } exp_run_t;

   exp_run_t exp_q[$];
   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   int song_freq  [11] = '{262, 294, 330, 349, 392, 0, 392, 349, 330, 294, 262};
   int song_beats [11] = '{2, 2, 2, 2, 4, 2, 2, 2, 2, 2, 4};

   function automatic logic [25:0] pack(input int f, input int en, input bit busy,
                                        input int idx, input bit done);
      return {16'(f), 4'(en), busy, 4'(idx), done};
   endfunction

   logic [25:0] idle_t;
   initial idle_t = pack(0, 0, 1'b0, 0, 1'b0);

   // Adjacent identical runs merge, since the DUT shows them as one.
   task automatic push_run(input logic [25:0] t, input int len);
      exp_run_t r;
      if (len > 0 && exp_q.size() > 0 && exp_q[$].t == t && exp_q[$].len > 0) begin
         r = exp_q.pop_back();
         r.len = r.len + len;
         exp_q.push_back(r);
      end else begin
         r.t   = t;
         r.len = len;
         exp_q.push_back(r);
      end
   endtask

   task automatic push_load(input int k);
      push_run(pack(0, 0, 1'b1, k, 1'b0), 1);
   endtask

   task automatic push_tone(input int k, input int len);
      push_run(pack(song_freq[k], (song_freq[k] != 0) ? 15 : 0, 1'b1, k, 1'b0), len);
   endtask

   task automatic push_note(input int k);
      push_load(k);
      push_tone(k, song_beats[k] * BEAT);
      push_run(pack(0, 0, 1'b1, k, 1'b0), GAP);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_for(input int f, input int idx, input string name);
      int n = 0;
      checks++;
      while (!(o_freq == 16'(f) && o_note_idx == 4'(idx)) && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= WAIT_LIMIT) begin
         errors++;
         $display("FAIL wait_%s: freq=%0d idx=%0d never appeared (last freq=%0d idx=%0d)",
                  name, f, idx, o_freq, o_note_idx);
      end
   endtask

   // Monitor: accumulate runs of identical outputs, score each finished run.
   logic [25:0] run_t;
   int          run_len = 0;
   bit          run_open = 1'b0;
   int          run_no = 0;

   initial begin
      logic [25:0] cur;
      exp_run_t    e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = {o_freq, o_en, o_busy, o_note_idx, o_done};
            if (!run_open) begin
               run_t    = cur;
               run_len  = 1;
               run_open = 1'b1;
            end else if (cur == run_t) begin
               run_len++;
            end else begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL run%0d: got=%h len=%0d, required=<none queued>",
                           run_no, run_t, run_len);
               end else begin
                  e = exp_q.pop_front();
                  if (e.t != run_t || (e.len != 0 && e.len != run_len)) begin
                     errors++;
                     $display("FAIL run%0d: got freq=%0d en=%h busy=%b idx=%0d done=%b len=%0d, required freq=%0d en=%h busy=%b idx=%0d done=%b len=%0d",
                              run_no, run_t[25:10], run_t[9:6], run_t[5], run_t[4:1], run_t[0], run_len,
                              e.t[25:10], e.t[9:6], e.t[5], e.t[4:1], e.t[0], e.len);
                  end
               end
               run_no++;
               run_t   = cur;
               run_len = 1;
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      push_run(idle_t, 0);
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      // Full song from IDLE.
      for (int k = 0; k < 11; k++) push_note(k);
      push_load(11);
`ifdef MELODY_SEQUENCER_LOOP_EN
      push_load(0);
      push_tone(0, 1);
      push_run(idle_t, 0);
      pulse_start();
      wait_for(0, 11, "end_marker");
      wait_for(262, 0, "loop_restart");
      pulse_stop();
`else
      push_run(pack(0, 0, 1'b1, 0, 1'b1), 1);
      push_run(idle_t, 0);
      pulse_start();
      repeat (320) @(negedge clk);
`endif
      repeat (3) @(negedge clk);

      // Stop during note 4.
      for (int k = 0; k < 4; k++) push_note(k);
      push_load(4);
      push_tone(4, 5);
      push_run(idle_t, 0);
      pulse_start();
      wait_for(392, 4, "note4");
      repeat (4) @(negedge clk);
      pulse_stop();
      repeat (5) @(negedge clk);

      // Reset mid-tone, with start held high during reset.
      push_load(0);
      push_tone(0, 4);
      push_run(idle_t, 0);
      pulse_start();
      wait_for(262, 0, "reset_note0");
      repeat (3) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (10) @(negedge clk);

      // Start and stop together during a tone: stop wins.
      push_load(0);
      push_tone(0, 3);
      push_run(idle_t, 0);
      pulse_start();
      wait_for(262, 0, "both_note0");
      repeat (2) @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      repeat (5) @(negedge clk);

      // Restart mid-song during note 2.
      push_note(0);
      push_note(1);
      push_load(2);
      push_tone(2, 4);
      push_load(0);
      push_tone(0, 1);
      push_run(idle_t, 0);
      pulse_start();
      wait_for(330, 2, "note2");
      repeat (3) @(negedge clk);
      pulse_start();
      wait_for(262, 0, "restart_note0");
      pulse_stop();
      repeat (6) @(negedge clk);

      // The final idle run is still open; it must be the last expectation.
      mon_en = 1'b0;
      @(negedge clk);
      checks++;
      if (exp_q.size() != 1 || exp_q[0].t != run_t) begin
         errors++;
         $display("FAIL final_idle: got=%h with %0d runs queued, required=%h with 1 queued",
                  run_t, exp_q.size(), idle_t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
